// File: rtl/nios2_system_v0_data_in_fifo.sv
// Avalon-MM input port: filter samples enter a small FIFO, the CPU pops them.
// Optional DATA_IN_IRQ_EN: irqmask register (addr2) and registered irq output.
module nios2_system_v0_data_in_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              read_n,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    input  logic [DATA_W-1:0] in_port,
    input  logic              in_valid,
    output logic              in_ready
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q, ovf_d;
    logic [1:0]        mask_q, mask_d;
    logic [DATA_W-1:0] last_q, last_d;
    logic [31:0]       readdata_q, readdata_d;
    logic              irq_q, irq_d;

    logic rd, wr;
    logic empty, full;
    logic flush, ovf_clr;
    logic push, pop, drop;
    logic unused_wd;

    assign rd    = chipselect & ~read_n;
    assign wr    = chipselect & ~write_n;
    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);

    assign in_ready = ~full;
    assign readdata = readdata_q;
    assign irq      = irq_q;

    assign unused_wd = ^writedata;

    assign flush   = wr & (address == 2'd1) & writedata[0];
    assign ovf_clr = wr & (address == 2'd1) & writedata[10];

    // A flush swallows any concurrent push or pop without side effects.
    assign push = in_valid & ~full & ~flush;
    assign drop = in_valid & full & ~flush;
    assign pop  = rd & (address == 2'd0) & ~empty & ~flush;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        last_d  = last_q;
        ovf_d   = ovf_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wptr_d = wptr_q + 1'b1;
                last_d = in_port;
            end
            if (pop) begin
                rptr_d = rptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
        // Sticky overflow: a set in the same cycle wins over a clear.
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
    end

`ifdef DATA_IN_IRQ_EN
    always_comb begin
        mask_d = mask_q;
        if (wr && address == 2'd2) begin
            mask_d = writedata[1:0];
        end
        irq_d = (mask_d[0] & (count_d != '0)) | (mask_d[1] & ovf_d);
    end
`else
    always_comb begin
        mask_d = 2'b00;
        irq_d  = 1'b0;
    end
`endif

    always_comb begin
        readdata_d = readdata_q;
        if (rd) begin
            unique case (address)
                2'd0: begin
                    readdata_d = '0;
                    if (pop) begin
                        readdata_d[31]         = 1'b1;
                        readdata_d[DATA_W-1:0] = mem_q[rptr_q];
                    end
                end
                2'd1: begin
                    readdata_d       = '0;
                    readdata_d[7:0]  = 8'(count_q);
                    readdata_d[8]    = empty;
                    readdata_d[9]    = full;
                    readdata_d[10]   = ovf_q;
                end
                2'd2: readdata_d = {30'd0, mask_q};
                2'd3: readdata_d = 32'(last_q);
                default: readdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= in_port;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            mask_q     <= 2'b00;
            last_q     <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            mask_q     <= mask_d;
            last_q     <= last_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

endmodule

// File: tb/tb_nios2_system_v0_data_in_fifo.sv
// Directed bench for the data-in FIFO; read results flow through a scoreboard.
// Expectations for irq/addr2 follow DATA_IN_IRQ_EN.
module tb_nios2_system_v0_data_in_fifo;

`ifdef DATA_IN_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic [7:0]  in_port;
    logic        in_valid;
    logic        in_ready;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    nios2_system_v0_data_in_fifo #(.DEPTH(4), .DATA_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .read_n(read_n), .write_n(write_n),
        .writedata(writedata), .readdata(readdata), .irq(irq),
        .in_port(in_port), .in_valid(in_valid), .in_ready(in_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_compare();
        logic [31:0] e;
        string t;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard: observed %h expected none", readdata);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, readdata, e);
        end
    endtask

    // Read strobe one edge; optional concurrent sample from the filter.
    task automatic rd_x(string tag, logic [1:0] a, logic [31:0] e,
                        logic v, logic [7:0] d);
        address    = a;
        chipselect = 1'b1;
        read_n     = 1'b0;
        in_valid   = v;
        in_port    = d;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        tick();
        chipselect = 1'b0;
        read_n     = 1'b1;
        in_valid   = 1'b0;
        sb_compare();
    endtask

    task automatic rd(string tag, logic [1:0] a, logic [31:0] e);
        rd_x(tag, a, e, 1'b0, 8'h00);
    endtask

    task automatic wr_x(logic [1:0] a, logic [31:0] d, logic v, logic [7:0] s);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
        in_valid   = v;
        in_port    = s;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        in_valid   = 1'b0;
    endtask

    task automatic push(logic [7:0] d);
        in_valid = 1'b1;
        in_port  = d;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        read_n     = 1'b1;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = '0;
        in_valid   = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        push(8'h01);
        push(8'h02);

        // Reset with in_valid held discards contents
        reset_n  = 1'b0;
        in_valid = 1'b1;
        in_port  = 8'h77;
        tick();
        reset_n  = 1'b1;
        in_valid = 1'b0;
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_rdata", readdata, 32'd0);
        rd("rst_stat", 2'd1, 32'h100);
        rd("rst_last", 2'd3, 32'h0);
        rd("rst_pop", 2'd0, 32'h0);

        // Basic ordering
        push(8'h11);
        push(8'h22);
        push(8'h33);
        rd("pop0", 2'd0, 32'h8000_0011);
        rd("pop1", 2'd0, 32'h8000_0022);
        rd("pop2", 2'd0, 32'h8000_0033);
        rd("pop_empty", 2'd0, 32'h0);
        rd("last33", 2'd3, 32'h33);

        // Fill and overflow
        for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
        check("full_ready", 32'(in_ready), 32'd0);
        push(8'hFF);
        push(8'hFF);
        rd("full_ovf", 2'd1, 32'h604);
        rd("last_a3", 2'd3, 32'hA3);
        wr_x(2'd1, 32'h400, 1'b0, 8'h00);
        rd("ovf_clr", 2'd1, 32'h204);

        // Push while full and popping is still rejected
        rd_x("full_pop", 2'd0, 32'h8000_00A0, 1'b1, 8'h55);
        rd("after_fp", 2'd1, 32'h403);
        rd("pop_a1", 2'd0, 32'h8000_00A1);
        rd("pop_a2", 2'd0, 32'h8000_00A2);
        rd("pop_a3", 2'd0, 32'h8000_00A3);
        rd("drained", 2'd0, 32'h0);
        wr_x(2'd1, 32'h400, 1'b0, 8'h00);

        // Simultaneous push/pop on a partly filled FIFO
        push(8'hB1);
        push(8'hB2);
        rd_x("pp_pop", 2'd0, 32'h8000_00B1, 1'b1, 8'hB3);
        rd("pp_stat", 2'd1, 32'h002);
        rd("pp_b2", 2'd0, 32'h8000_00B2);
        rd("pp_b3", 2'd0, 32'h8000_00B3);

        // Push into empty: same-cycle pop sees nothing
        rd_x("pe_pop", 2'd0, 32'h0, 1'b1, 8'hC4);
        rd("pe_next", 2'd0, 32'h8000_00C4);

        // Writes to addr0/addr3 are ignored
        wr_x(2'd0, 32'hFFFF_FFFF, 1'b0, 8'h00);
        wr_x(2'd3, 32'hFFFF_FFFF, 1'b0, 8'h00);
        rd("wr_ign", 2'd1, 32'h100);
        rd("wr_ign3", 2'd3, 32'hC4);

        // Interrupts
        wr_x(2'd2, 32'h1, 1'b0, 8'h00);
        rd("mask1", 2'd2, IRQ_ON ? 32'h1 : 32'h0);
        check("irq_idle", 32'(irq), 32'd0);
        push(8'h7E);
        check("irq_ne", 32'(irq), 32'(IRQ_ON));
        rd("irq_pop", 2'd0, 32'h8000_007E);
        check("irq_off", 32'(irq), 32'd0);
        wr_x(2'd2, 32'h2, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) push(8'hD0 + 8'(i));
        check("irq_full", 32'(irq), 32'd0);
        push(8'hEE);
        check("irq_ovf", 32'(irq), 32'(IRQ_ON));
        wr_x(2'd1, 32'h401, 1'b0, 8'h00);
        check("irq_clr", 32'(irq), 32'd0);
        rd("flush_clr", 2'd1, 32'h100);
        wr_x(2'd2, 32'h0, 1'b0, 8'h00);

        // Flush with concurrent push
        push(8'h12);
        push(8'h34);
        rd("two", 2'd1, 32'h002);
        wr_x(2'd1, 32'h1, 1'b1, 8'h99);
        rd("fl_pop", 2'd0, 32'h0);
        rd("fl_stat", 2'd1, 32'h100);
        rd("fl_last", 2'd3, 32'h34);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL sb_left: observed %0d expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nios2_system_v0_data_in_fifo.md
Name: nios2_system_v0_data_in_fifo

Overview:
Avalon-MM slave input port: the return path from the convolution filter to the Nios II CPU. Filter pushes 8-bit result samples via valid/ready into a small FIFO; CPU pops them through the register map. Complements the 8-bit output PIO that drives pixels into the filter.

Parameters:
DEPTH, 4, FIFO entries; power of 2, min 2
DATA_W, 8, sample width; max 24

Ports:
clk  in  1  system clock; all logic on rising edge
reset_n  in  1  synchronous active-low reset, sampled on rising clk
address  in  2  Avalon word address
chipselect  in  1  Avalon slave select
read_n  in  1  active-low read strobe
write_n  in  1  active-low write strobe
writedata  in  32  Avalon write data
readdata  out  32  Avalon read data, registered, read latency 1
irq  out  1  level interrupt to CPU
in_port  in  DATA_W  sample from filter
in_valid  in  1  sample valid
in_ready  out  1  FIFO can accept (= not full)

Behaviour:
- Reset (reset_n=0 at clk edge): FIFO empty (count=0, pointers 0), overflow=0, irqmask=0, last=0, readdata=0, irq=0, in_ready=1. Reset mid-transfer discards all contents.
- rd = chipselect & ~read_n; wr = chipselect & ~write_n.
- Register map (readdata updated on edge after rd; unused bits 0):
  - addr0 R: {valid bit31, head[DATA_W-1:0]}; if not empty, pops head, valid=1; if empty, valid=0, data 0, no pointer change.
  - addr1 R: [7:0] count, [8] empty, [9] full, [10] overflow. W: bit0=1 flush FIFO; bit10=1 clears overflow.
  - addr2 R/W: irqmask[1:0]; bit0 not-empty enable, bit1 overflow enable.
  - addr3 R: last accepted sample (peek; no pop). Writes ignored.
- Writes to addr0/addr3 ignored. A read has no side effect except at addr0.
- Push: in_valid & in_ready at clk edge -> write at wptr, wptr+1 mod DEPTH, last <= in_port.
- in_ready = (count != DEPTH), combinational from count only; push while full rejected even if pop occurs same cycle.
- in_valid & ~in_ready -> sample dropped, overflow <= 1 (sticky). Set beats clear in the same cycle.
- Push and pop same cycle (non-empty, not full): both happen, count unchanged; popped word is old head.
- Push into empty FIFO: word readable at addr0 from next cycle; the same-cycle pop returns valid=0.
- Flush: count, pointers <= 0; concurrent push discarded, overflow not set; concurrent pop returns valid=0. last unaffected.
- count is 0..DEPTH; wrap via pointer modulo, no separate full flag storage beyond count.
- irq registered: irq <= (mask[0] & ~empty) | (mask[1] & overflow), using next-state values; 1 cycle after cause.

Optional Feature:
DATA_IN_IRQ_EN — defined: irqmask register and irq logic as above. Undefined: irq tied 0, addr2 reads 0, writes to addr2 ignored; FIFO and overflow logic unchanged.

Test Plan:
- Reset: assert reset_n=0 one edge with in_valid=1 -> count=0, in_ready=1, irq=0, addr1 reads 0x100.
- Push 0x11,0x22,0x33 then read addr0 x4 -> 0x80000011, 0x80000022, 0x80000033, 0x00000000; addr3 reads 0x33.
- Fill DEPTH=4 with 0xA0..0xA3, hold in_valid with 0xFF -> in_ready=0, addr1 = 0x604, 0xFF never popped; write addr1 0x400 -> overflow clears, reads 0x204.
- Full FIFO, simultaneous in_valid 0x55 and addr0 read -> pop returns 0x800000A0, 0x55 dropped, count=3, overflow=1.
- irqmask=1, push 0x7E -> irq=1 one cycle after push; pop it -> irq=0 one cycle later; with macro undefined irq stays 0.
- Count=2, write addr1 0x1 with concurrent push 0x99 -> count=0, addr0 returns valid=0, overflow=0.
